fpu_addsub_pipe: RTL and testbench

//   Pipelined floating-point add/subtract unit. Parametrised successor of the single-cycle FPU adder.

---
 rtl/fpu_addsub_pipe.sv | 190 +++++++++++++++++++
 tb/tb_fpu_addsub_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_pipe.sv
// fpu_addsub_pipe: three-stage floating-point add/subtract (align, add, normalise/round) with valid/ready.
// Define FPU_ADDSUB_SATURATE_EN to clamp overflow to the largest finite value instead of infinity.
module fpu_addsub_pipe #(
  parameter int EXP_WIDTH  = 11,
  parameter int MANT_WIDTH = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          op_sub,
  input  logic [EXP_WIDTH+MANT_WIDTH:0] op_a_in,
  input  logic [EXP_WIDTH+MANT_WIDTH:0] op_b_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [EXP_WIDTH+MANT_WIDTH:0] data_out,
  output logic [3:0]                    status_out
);
  localparam int W   = 1 + EXP_WIDTH + MANT_WIDTH;
  localparam int SW  = MANT_WIDTH + 4;
  localparam int EW  = EXP_WIDTH + 2;
  localparam int LZW = $clog2(SW + 1);
  localparam logic [EXP_WIDTH-1:0]  EXP_MAX  = '1;
  localparam logic signed [EW-1:0]  EXP_ONE  = EW'(1);
  localparam logic signed [EW-1:0]  EXP_ZERO = '0;
  localparam logic signed [EW-1:0]  EXP_LIM  = signed'({2'b00, EXP_MAX});

  function automatic logic [SW-1:0] f_align(input logic [MANT_WIDTH:0] sig,
                                            input logic [EXP_WIDTH-1:0] d);
    logic [SW-1:0] ext;
    logic [SW-1:0] mask;
    ext = {sig, 3'b000};
    if (int'(d) >= SW) return {{(SW-1){1'b0}}, |sig};
    mask = ~({SW{1'b1}} << d);
    return (ext >> d) | {{(SW-1){1'b0}}, |(ext & mask)};
  endfunction

  function automatic logic [LZW-1:0] f_lzc(input logic [SW-1:0] v);
    logic [LZW-1:0] n;
    n = LZW'(SW);
    for (int i = 0; i < SW; i++)
      if (v[i]) n = LZW'(SW - 1 - i);
    return n;
  endfunction

  // Returns {rounding carry, fraction}; the carry means the significand reached 2.0.
  function automatic logic [MANT_WIDTH:0] f_rne(input logic [SW-1:0] n);
    logic                  rup;
    logic [MANT_WIDTH+1:0] m;
    rup = n[2] & (n[1] | n[0] | n[3]);
    m   = {1'b0, n[SW-1:3]} + {{(MANT_WIDTH+1){1'b0}}, rup};
    return m[MANT_WIDTH+1] ? {1'b1, m[MANT_WIDTH:1]} : {1'b0, m[MANT_WIDTH-1:0]};
  endfunction

  function automatic logic [W-1:0] f_ovf(input logic s);
`ifdef FPU_ADDSUB_SATURATE_EN
    return {s, {(EXP_WIDTH-1){1'b1}}, 1'b0, {MANT_WIDTH{1'b1}}};
`else
    return {s, EXP_MAX, {MANT_WIDTH{1'b0}}};
`endif
  endfunction

  logic                 r_vld_p1, r_vld_p2, r_vld_p3;
  logic [W-1:0]         r_data_p3;
  logic [3:0]           r_status_p3;
  logic                 w_stall, w_accept;

  assign w_stall    = r_vld_p3 && !out_ready;
  assign in_ready   = !w_stall;
  assign w_accept   = in_valid && in_ready;
  assign out_valid  = r_vld_p3;
  assign data_out   = r_data_p3;
  assign status_out = r_status_p3;

  // ---- Stage 1: unpack, order by magnitude, align the smaller significand ----
  logic                  w_a_sign, w_b_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_swap;
  logic [EXP_WIDTH-1:0]  w_a_exp, w_b_exp, w_l_exp, w_s_exp, w_diff;
  logic [W-2:0]          w_a_mag, w_b_mag;
  logic [MANT_WIDTH:0]   w_a_sig, w_b_sig, w_l_sig, w_s_sig;

  assign w_a_sign = op_a_in[W-1];
  assign w_b_sign = op_b_in[W-1] ^ op_sub;
  assign w_a_exp  = op_a_in[W-2:MANT_WIDTH];
  assign w_b_exp  = op_b_in[W-2:MANT_WIDTH];
  assign w_a_zero = (w_a_exp == '0);
  assign w_b_zero = (w_b_exp == '0);
  assign w_a_inf  = (w_a_exp == EXP_MAX);
  assign w_b_inf  = (w_b_exp == EXP_MAX);
  assign w_a_mag  = w_a_zero ? '0 : op_a_in[W-2:0];
  assign w_b_mag  = w_b_zero ? '0 : op_b_in[W-2:0];
  assign w_a_sig  = w_a_zero ? '0 : {1'b1, op_a_in[MANT_WIDTH-1:0]};
  assign w_b_sig  = w_b_zero ? '0 : {1'b1, op_b_in[MANT_WIDTH-1:0]};
  assign w_swap   = (w_b_mag > w_a_mag);
  assign w_l_exp  = w_swap ? w_b_exp : w_a_exp;
  assign w_s_exp  = w_swap ? w_a_exp : w_b_exp;
  assign w_l_sig  = w_swap ? w_b_sig : w_a_sig;
  assign w_s_sig  = w_swap ? w_a_sig : w_b_sig;
  assign w_diff   = w_l_exp - w_s_exp;

  logic                 r_sign_p1, r_esub_p1, r_inf_p1, r_nan_p1;
  logic [EXP_WIDTH-1:0] r_exp_p1;
  logic [SW-1:0]        r_lsig_p1, r_ssig_p1;

  // ---- Stage 2: effective add or subtract (larger minus smaller) ----
  logic [SW:0] w_sum_s2;
  assign w_sum_s2 = r_esub_p1 ? ({1'b0, r_lsig_p1} - {1'b0, r_ssig_p1})
                              : ({1'b0, r_lsig_p1} + {1'b0, r_ssig_p1});

  logic                 r_sign_p2, r_esub_p2, r_inf_p2, r_nan_p2;
  logic [EXP_WIDTH-1:0] r_exp_p2;
  logic [SW:0]          r_sum_p2;

  // ---- Stage 3: normalise, round to nearest even, classify and pack ----
  logic [LZW-1:0]        w_lz;
  logic [SW-1:0]         w_norm;
  logic signed [EW-1:0]  w_exp_n, w_exp_r;
  logic [MANT_WIDTH:0]   w_rnd;
  logic                  w_inexact;
  logic [W-1:0]          w_data_s3;
  logic [3:0]            w_status_s3;

  always_comb begin
    w_lz        = f_lzc(r_sum_p2[SW-1:0]);
    w_norm      = r_sum_p2[SW-1:0] << w_lz;
    w_exp_n     = signed'({2'b00, r_exp_p2}) - signed'(EW'(w_lz));
    if (r_sum_p2[SW]) begin
      w_norm  = {r_sum_p2[SW:2], r_sum_p2[1] | r_sum_p2[0]};
      w_exp_n = signed'({2'b00, r_exp_p2}) + EXP_ONE;
    end
    w_rnd       = f_rne(w_norm);
    w_exp_r     = w_rnd[MANT_WIDTH] ? (w_exp_n + EXP_ONE) : w_exp_n;
    w_inexact   = |w_norm[2:0];
    w_data_s3   = {r_sign_p2, w_exp_r[EXP_WIDTH-1:0], w_rnd[MANT_WIDTH-1:0]};
    w_status_s3 = {!w_inexact, 2'b00, w_inexact};
    if (r_nan_p2) begin
      w_data_s3   = {1'b0, EXP_MAX, 1'b1, {(MANT_WIDTH-1){1'b0}}};
      w_status_s3 = 4'b0100;
    end else if (r_inf_p2) begin
      w_data_s3   = {r_sign_p2, EXP_MAX, {MANT_WIDTH{1'b0}}};
      w_status_s3 = 4'b1000;
    end else if (r_sum_p2 == '0) begin
      // Cancellation gives +0; two like-signed zeros keep their sign.
      w_data_s3   = {r_sign_p2 & !r_esub_p2, {(W-1){1'b0}}};
      w_status_s3 = 4'b1000;
    end else if (w_exp_r >= EXP_LIM) begin
      w_data_s3   = f_ovf(r_sign_p2);
      w_status_s3 = 4'b0101;
    end else if (w_exp_r <= EXP_ZERO) begin
      w_data_s3   = {r_sign_p2, {(W-1){1'b0}}};
      w_status_s3 = 4'b0011;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_vld_p3    <= 1'b0;
      r_data_p3   <= '0;
      r_status_p3 <= '0;
    end else if (!w_stall) begin
      r_vld_p1 <= w_accept;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
      if (r_vld_p2) begin
        r_data_p3   <= w_data_s3;
        r_status_p3 <= w_status_s3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!w_stall) begin
      r_sign_p1 <= w_swap ? w_b_sign : w_a_sign;
      r_esub_p1 <= w_a_sign ^ w_b_sign;
      r_inf_p1  <= w_a_inf | w_b_inf;
      r_nan_p1  <= w_a_inf & w_b_inf & (w_a_sign ^ w_b_sign);
      r_exp_p1  <= w_l_exp;
      r_lsig_p1 <= {w_l_sig, 3'b000};
      r_ssig_p1 <= f_align(w_s_sig, w_diff);
      r_sign_p2 <= r_sign_p1;
      r_esub_p2 <= r_esub_p1;
      r_inf_p2  <= r_inf_p1;
      r_nan_p2  <= r_nan_p1;
      r_exp_p2  <= r_exp_p1;
      r_sum_p2  <= w_sum_s2;
    end
  end

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Bench for fpu_addsub_pipe: directed vectors, a stalled stream, random traffic against a real-valued model.
module tb_fpu_addsub_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [W-1:0] op_a_in, op_b_in, data_out;
  logic [3:0]   status_out;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [35:0]  sb_q[$];
  logic         held_v  = 1'b0;
  logic [35:0]  held;

  fpu_addsub_pipe #(.EXP_WIDTH(11), .MANT_WIDTH(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .op_a_in(op_a_in), .op_b_in(op_b_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .status_out(status_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic real f_val(input logic [W-1:0] x, input logic s);
    real m;
    int  e;
    if (x[30:20] == 11'd0) return 0.0;
    m = 1.0 + real'(x[19:0]) / 1048576.0;
    e = int'(x[30:20]) - 1023 - 2;  // quarter scale keeps 2*max inside double range
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return s ? -m : m;
  endfunction

  function automatic logic [W-1:0] ovf_word(input logic s);
`ifdef FPU_ADDSUB_SATURATE_EN
    return {s, 31'h7FEFFFFF};
`else
    return {s, 31'h7FF00000};
`endif
  endfunction

  function automatic logic [35:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic sub);
    logic   sa, sb, za, zb, ia, ib, far, s, inexact, up;
    int     ea, eb, e, d;
    real    x, m, sc, fl, rem;
    longint mant;
    sa = a[31]; sb = b[31] ^ sub;
    ea = int'(a[30:20]); eb = int'(b[30:20]);
    za = (ea == 0); zb = (eb == 0); ia = (ea == 2047); ib = (eb == 2047);
    if (ia && ib && (sa != sb)) return {4'b0100, 32'h7FF80000};
    if (ia) return {4'b1000, sa, 31'h7FF00000};
    if (ib) return {4'b1000, sb, 31'h7FF00000};
    x = f_val(a, sa) + f_val(b, sb);
    if (x == 0.0) return {4'b1000, (za && zb) ? (sa & sb) : 1'b0, 31'h0};
    d = (ea > eb) ? ea - eb : eb - ea;
    far = !za && !zb && (d > 30);
    s = (x < 0.0);
    m = s ? -x : x;
    e = 1023 + 2;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    sc = m * 1048576.0;
    fl = $floor(sc);
    rem = sc - fl;
    mant = longint'(fl);
    inexact = far || (rem != 0.0);
    up = (rem > 0.5) || ((rem == 0.5) && mant[0]);
    mant = mant + longint'(up);
    if (mant == 64'd2097152) begin mant = 64'd1048576; e++; end
    if (e >= 2047) return {4'b0101, ovf_word(s)};
    if (e <= 0)    return {4'b0011, s, 31'h0};
    return {!inexact, 2'b00, inexact, s, 11'(e), 20'(mant)};
  endfunction

  function automatic int rnd_base();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(1, 40));
      1:       return int'($urandom_range(2000, 2046));
      default: return int'($urandom_range(1, 2046));
    endcase
  endfunction

  function automatic logic [W-1:0] rnd_op(input int base);
    int          k, e;
    logic [19:0] f;
    k = int'($urandom_range(0, 19));
    f = 20'($urandom);
    case (k)
      0:       e = 0;
      1:       e = 2047;
      2:       e = int'($urandom_range(1, 2046));
      default: begin
        e = base + int'($urandom_range(0, 48)) - 24;
        if (e < 1) e = 1;
        if (e > 2046) e = 2046;
      end
    endcase
    if (k == 3) f = '1;
    else if (k == 4) f = '0;
    return {1'($urandom), 11'(e), f};
  endfunction

  task automatic cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sub, input logic ordy, input logic use_want,
                       input logic [35:0] want, output logic acc);
    @(negedge clk);
    in_valid = v; op_a_in = a; op_b_in = b; op_sub = sub; out_ready = ordy;
    #1;
    if (held_v) chk("stall_hold", {status_out, data_out}, held);
    held_v = out_valid && !out_ready;
    held   = {status_out, data_out};
    chk("in_ready", in_ready, !(out_valid && !out_ready));
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("extra_result", out_valid, 1'b0);
      else chk("result", {status_out, data_out}, sb_q.pop_front());
    end
    acc = v && in_ready;
    if (acc) sb_q.push_back(use_want ? want : ref_model(a, b, sub));
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 40 && sb_q.size() > 0; i++)
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);
    chk("drain_left", sb_q.size(), 0);
  endtask

  logic [W-1:0] dir_a[5] = '{32'h3FF00000, 32'h3FF00000, 32'h3FF00000, 32'h7FEFFFFF, 32'h00100001};
  logic [W-1:0] dir_b[5] = '{32'h3FF00000, 32'h3FF00000, 32'h3EA00000, 32'h7FEFFFFF, 32'h00100000};
  logic         dir_s[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
`ifdef FPU_ADDSUB_SATURATE_EN
  logic [35:0]  dir_w[5] = '{{4'b1000, 32'h40000000}, {4'b1000, 32'h0}, {4'b0001, 32'h3FF00000},
                             {4'b0101, 32'h7FEFFFFF}, {4'b0011, 32'h0}};
`else
  logic [35:0]  dir_w[5] = '{{4'b1000, 32'h40000000}, {4'b1000, 32'h0}, {4'b0001, 32'h3FF00000},
                             {4'b0101, 32'h7FF00000}, {4'b0011, 32'h0}};
`endif

  initial begin
    logic         acc, v, ordy, sub;
    logic [W-1:0] a, b;
    int           issued, cyc, base;

    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; op_a_in = '0; op_b_in = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_data", data_out, '0);
    chk("rst_status", status_out, '0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, dir_a[i], dir_b[i], dir_s[i], 1'b1, 1'b1, dir_w[i], acc);
      chk("dir_accept", acc, 1'b1);
    end
    drain();

    issued = 0; cyc = 0;
    base = rnd_base(); a = rnd_op(base); b = rnd_op(base); sub = 1'($urandom);
    while (issued < 8 && cyc < 40) begin
      cyc++;
      cycle(1'b1, a, b, sub, !(cyc >= 4 && cyc <= 6), 1'b0, '0, acc);
      if (cyc >= 4 && cyc <= 6) chk("stall_in_ready", in_ready, 1'b0);
      if (acc) begin
        issued++;
        base = rnd_base(); a = rnd_op(base); b = rnd_op(base); sub = 1'($urandom);
      end
    end
    chk("stream_issued", issued, 8);
    drain();

    for (int i = 0; i < 400; i++) begin
      base = rnd_base();
      a = rnd_op(base);
      b = ($urandom_range(0, 9) == 0) ? a : rnd_op(base);
      v = ($urandom_range(0, 9) < 8);
      ordy = ($urandom_range(0, 3) != 0);
      cycle(v, a, b, 1'($urandom), ordy, 1'b0, '0, acc);
    end
    drain();

    for (int i = 0; i < 3; i++) begin
      base = rnd_base();
      cycle(1'b1, rnd_op(base), rnd_op(base), 1'($urandom), 1'b1, 1'b0, '0, acc);
    end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    @(negedge clk);
    chk("midrst_out_valid_edge", out_valid, 1'b0);
    chk("midrst_data", data_out, '0);
    rst = 1'b0;
    sb_q.delete();
    held_v = 1'b0;
    for (int i = 0; i < 6; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, acc);
    chk("post_rst_idle", out_valid, 1'b0);

    for (int i = 0; i < 60; i++) begin
      base = rnd_base();
      cycle(1'b1, rnd_op(base), rnd_op(base), 1'($urandom), ($urandom_range(0, 2) != 0),
            1'b0, '0, acc);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
